// File: rtl/vga_timing_pkg.sv
// Shared timing types, standard raster modes and counter sizing helper
// for the parametrised VGA timing driver.
package vga_timing_pkg;

    typedef struct packed {
        int h_front;
        int h_sync;
        int h_back;
        int h_act;
        int v_front;
        int v_sync;
        int v_back;
        int v_act;
    } mode_t;

    localparam mode_t MODE_640X480 =
        '{16, 96, 48, 640, 10, 2, 33, 480};
    localparam mode_t MODE_800X600 =
        '{40, 128, 88, 800, 1, 4, 23, 600};
    localparam mode_t MODE_1024X768 =
        '{24, 136, 160, 1024, 3, 6, 29, 768};

    function automatic int min_cnt_w(input mode_t m);
        int ht;
        int vt;
        ht = m.h_front + m.h_sync + m.h_back + m.h_act;
        vt = m.v_front + m.v_sync + m.v_back + m.v_act;
        return $clog2(ht > vt ? ht : vt);
    endfunction

    localparam int DEF_CNT_W = min_cnt_w(MODE_640X480);

endpackage

// File: rtl/vga_timing_driver_if.sv
// Pixel fetch bus between the timing driver (master) and the
// pixel source (slave).
interface vga_timing_driver_if
    import vga_timing_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int COLOR_W = 10
);
    logic               request;
    logic [CNT_W-1:0]   current_x;
    logic [CNT_W-1:0]   current_y;
    logic               sof;
    logic               sol;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;

    modport master (
        output request, current_x, current_y, sof, sol,
        input  r, g, b
    );

    modport slave (
        input  request, current_x, current_y, sof, sol,
        output r, g, b
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with enable plus
// front/sync/back/active region decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int W     = 10,
    parameter int FRONT = 16,
    parameter int SYNC  = 96,
    parameter int BACK  = 48,
    parameter int ACT   = 640
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         in_sync,
    output logic         in_act
);
    localparam int BLANK = FRONT + SYNC + BACK;
    localparam int TOTAL = BLANK + ACT;

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_LO = W'(FRONT);
    localparam logic [W-1:0] SYNC_HI = W'(FRONT + SYNC);
    localparam logic [W-1:0] ACT_LO  = W'(BLANK);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign in_sync = (cnt >= SYNC_LO) && (cnt < SYNC_HI);
    assign in_act  = (cnt >= ACT_LO);

endmodule

// File: rtl/vga_timing_driver.sv
// Parametrised VGA raster generator: registered DAC-side outputs and a
// combinational pixel request issued LEAD cycles ahead of display.
module vga_timing_driver
    import vga_timing_pkg::*;
#(
    parameter int COLOR_W = 10,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int H_FRONT = MODE_640X480.h_front,
    parameter int H_SYNC  = MODE_640X480.h_sync,
    parameter int H_BACK  = MODE_640X480.h_back,
    parameter int H_ACT   = MODE_640X480.h_act,
    parameter int V_FRONT = MODE_640X480.v_front,
    parameter int V_SYNC  = MODE_640X480.v_sync,
    parameter int V_BACK  = MODE_640X480.v_back,
    parameter int V_ACT   = MODE_640X480.v_act,
    parameter int HS_NEG  = 1,
    parameter int VS_NEG  = 1,
    parameter int LEAD    = 1
) (
    input  logic               clk27,
    input  logic               rst27,
    vga_timing_driver_if.master pix,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank,
    output logic               vga_clock
);
    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int H_TOTAL = H_BLANK + H_ACT;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int V_TOTAL = V_BLANK + V_ACT;

    if (LEAD < 1 || LEAD > H_BLANK - 1) begin : g_bad_lead
        $error("vga_timing_driver: LEAD out of range");
    end
    if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_bad_w
        $error("vga_timing_driver: CNT_W too small");
    end

    localparam logic [CNT_W:0]   HB_X   = (CNT_W+1)'(H_BLANK);
    localparam logic [CNT_W:0]   HT_X   = (CNT_W+1)'(H_TOTAL);
    localparam logic [CNT_W:0]   LEAD_X = (CNT_W+1)'(LEAD);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] VB     = CNT_W'(V_BLANK);
    localparam logic             HS_OFF = (HS_NEG != 0);
    localparam logic             VS_OFF = (VS_NEG != 0);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_sync, h_act;
    logic             v_sync, v_act;
    logic             h_wrap, act;
    logic [CNT_W:0]   h_lead;
    logic             req;
    logic [CNT_W-1:0] cx, cy;

    assign h_wrap = (h_cnt == H_LAST);
    assign act    = h_act && v_act;

    vga_axis_counter #(
        .W(CNT_W), .FRONT(H_FRONT), .SYNC(H_SYNC),
        .BACK(H_BACK), .ACT(H_ACT)
    ) u_h (
        .clk(clk27), .rst(rst27), .en(1'b1),
        .cnt(h_cnt), .in_sync(h_sync), .in_act(h_act)
    );

    vga_axis_counter #(
        .W(CNT_W), .FRONT(V_FRONT), .SYNC(V_SYNC),
        .BACK(V_BACK), .ACT(V_ACT)
    ) u_v (
        .clk(clk27), .rst(rst27), .en(h_wrap),
        .cnt(v_cnt), .in_sync(v_sync), .in_act(v_act)
    );

    // One extra bit so h_cnt+LEAD never wraps back into the active range
    assign h_lead = {1'b0, h_cnt} + LEAD_X;
    assign req    = (h_lead >= HB_X) && (h_lead < HT_X) && v_act;
    assign cx     = req ? CNT_W'(h_lead - HB_X) : '0;
    assign cy     = req ? v_cnt - VB : '0;

    assign pix.request   = req;
    assign pix.current_x = cx;
    assign pix.current_y = cy;
    assign pix.sol       = req && (cx == '0);
    assign pix.sof       = req && (cx == '0) && (cy == '0);

    always_ff @(posedge clk27) begin
        if (rst27) begin
            vga_hs    <= HS_OFF;
            vga_vs    <= VS_OFF;
            vga_blank <= 1'b0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
        end else begin
            vga_hs    <= h_sync ^ HS_OFF;
            vga_vs    <= v_sync ^ VS_OFF;
            vga_blank <= act;
            vga_r     <= act ? pix.r : '0;
            vga_g     <= act ? pix.g : '0;
            vga_b     <= act ? pix.b : '0;
        end
    end

    assign vga_clock = ~clk27;

endmodule
